// File: rtl/btn_step_frontend.sv
// Board input front end: synchronises and debounces btn/sw, emits edge pulses,
// and turns btn[0] into a count strobe that auto-repeats while the button is held.
module btn_step_frontend #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int REPEAT_DELAY    = 62500000,
  parameter int REPEAT_PERIOD   = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [1:0] sw,
  output logic [3:0] btn_db,
  output logic [3:0] btn_rise,
  output logic [3:0] btn_fall,
  output logic [1:0] sw_db,
  output logic       step,
  output logic       dir
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DLY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] PER_LAST = TM_W'(REPEAT_PERIOD - 1);

  // Bits [3:0] are buttons, [5:4] are switches, all handled identically.
  logic [5:0] raw;
  logic [5:0] sync_meta;
  logic [5:0] sync_s;
  logic [5:0] stable;
  logic [5:0] flip;

  assign raw = {sw, btn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= raw;
      sync_s    <= sync_meta;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic            stable_q;
    logic            differ;

    assign differ    = sync_s[i] ^ stable_q;
    assign flip[i]   = differ && (cnt == DB_LAST);
    assign stable[i] = stable_q;

    // Any cycle of agreement clears the count, so glitches never accumulate.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt      <= '0;
        stable_q <= 1'b0;
      end else if (!differ) begin
        cnt <= '0;
      end else if (flip[i]) begin
        cnt      <= '0;
        stable_q <= ~stable_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Edge pulses are registered alongside the stable flip so they align with btn_db.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_rise <= '0;
      btn_fall <= '0;
    end else begin
      btn_rise <= flip[3:0] & sync_s[3:0];
      btn_fall <= flip[3:0] & ~sync_s[3:0];
    end
  end

  assign btn_db = stable[3:0];
  assign sw_db  = stable[5:4];
  assign dir    = stable[5];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TM_W-1:0] timer;
  logic [TM_W-1:0] timer_nx;
  logic            step_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      step  <= step_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (btn_rise[0]) state_nx = ST_DELAY;
      ST_DELAY: begin
        if (!btn_db[0])             state_nx = ST_IDLE;
        else if (timer == DLY_LAST) state_nx = ST_REPEAT;
      end
      ST_REPEAT: if (!btn_db[0]) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Release is checked before expiry, so letting go on the expiry cycle yields no step.
  always_comb begin
    step_nx  = 1'b0;
    timer_nx = timer + 1'b1;
    case (state)
      ST_IDLE:   step_nx = btn_rise[0];
      ST_DELAY:  step_nx = btn_db[0] && (timer == DLY_LAST);
      ST_REPEAT: step_nx = btn_db[0] && (timer == PER_LAST);
      default:   step_nx = 1'b0;
    endcase
    if ((state_nx != state) || step_nx || (state == ST_IDLE)) timer_nx = '0;
  end

endmodule

// File: tb/tb_btn_step_frontend.sv
// Directed bench for btn_step_frontend: every output edge is an event checked
// against an expected-event queue keyed by clock cycle number.
module tb_btn_step_frontend;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 4;
  localparam int K_DBUP  = 8;
  localparam int K_DBDN  = 12;
  localparam int K_STEP  = 16;
  localparam int K_DIRUP = 17;
  localparam int K_DIRDN = 18;
  localparam int K_SW0UP = 19;
  localparam int K_SW0DN = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [1:0] sw;
  logic [3:0] btn_db;
  logic [3:0] btn_rise;
  logic [3:0] btn_fall;
  logic [1:0] sw_db;
  logic       step;
  logic       dir;

  btn_step_frontend #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .sw(sw),
    .btn_db(btn_db),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .sw_db(sw_db),
    .step(step),
    .dir(dir)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  logic [23:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 24'd1;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];

  function automatic string kname(input int k);
    if (k < K_FALL)       return $sformatf("rise%0d", k - K_RISE);
    else if (k < K_DBUP)  return $sformatf("fall%0d", k - K_FALL);
    else if (k < K_DBDN)  return $sformatf("db_up%0d", k - K_DBUP);
    else if (k < K_STEP)  return $sformatf("db_dn%0d", k - K_DBDN);
    else if (k == K_STEP) return "step";
    else if (k == K_DIRUP) return "dir_up";
    else if (k == K_DIRDN) return "dir_dn";
    else if (k == K_SW0UP) return "sw0_up";
    else                   return "sw0_dn";
  endfunction

  // ---------------- driver tasks ----------------
  task automatic expect_ev(input int kind, input int at);
    exp_q.push_back({8'(kind), 24'(at)});
  endtask

  task automatic btn_up(input int b, input int at);
    expect_ev(K_RISE + b, at);
    expect_ev(K_DBUP + b, at);
  endtask

  task automatic btn_dn(input int b, input int at);
    expect_ev(K_FALL + b, at);
    expect_ev(K_DBDN + b, at);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (int'(cyc) < target) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic observe(input int kind);
    logic [31:0] e;
    int          hit;
    e   = {8'(kind), cyc};
    hit = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (hit < 0 && exp_q[i] == e) hit = i;
    vectors++;
    if (hit >= 0) begin
      exp_q.delete(hit);
    end else begin
      miscompares++;
      $display("FAIL unexpected_event: got %s@%0d, expected no such event", kname(kind), cyc);
    end
  endtask

  logic [3:0] prev_db   = '0;
  logic       prev_dir  = 1'b0;
  logic       prev_sw0  = 1'b0;
  logic       prev_step = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int b = 0; b < 4; b++) begin
          if (btn_rise[b]) observe(K_RISE + b);
          if (btn_fall[b]) observe(K_FALL + b);
          if (btn_db[b] != prev_db[b]) observe(btn_db[b] ? K_DBUP + b : K_DBDN + b);
        end
        if (step) begin
          vectors++;
          if (prev_step) begin
            miscompares++;
            $display("FAIL step_width at cycle %0d: got 2 consecutive cycles, expected 1", cyc);
          end
          observe(K_STEP);
        end
        if (dir != prev_dir) observe(dir ? K_DIRUP : K_DIRDN);
        if (sw_db[0] != prev_sw0) observe(sw_db[0] ? K_SW0UP : K_SW0DN);
      end
      prev_db   = btn_db;
      prev_dir  = dir;
      prev_sw0  = sw_db[0];
      prev_step = step;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][23:0] <= cyc) begin
          vectors++;
          miscompares++;
          $display("FAIL missing_event at cycle %0d: got nothing, expected %s@%0d",
                   cyc, kname(int'(exp_q[i][31:24])), exp_q[i][23:0]);
          exp_q.delete(i);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int r0;
  int rel;
  int t;

  initial begin
    rst = 1'b1;
    btn = '0;
    sw  = '0;
    tick(3);
    check("rst_btn_db",   {4'd0, btn_db},   8'd0);
    check("rst_btn_rise", {4'd0, btn_rise}, 8'd0);
    check("rst_btn_fall", {4'd0, btn_fall}, 8'd0);
    check("rst_sw_db",    {6'd0, sw_db},    8'd0);
    check("rst_step",     {7'd0, step},     8'd0);
    check("rst_dir",      {7'd0, dir},      8'd0);
    #1 rst = 1'b0;
    tick(3);

    // Bouncing press, then hold through auto-repeat, release on a would-be expiry.
    btn[0] = 1'b1; tick(2);
    btn[0] = 1'b0; tick(2);
    btn[0] = 1'b1;
    r0 = int'(cyc) + DB + 2;
    btn_up(0, r0);
    expect_ev(K_STEP, r0 + 1);
    for (int j = 0; j < 11; j++) expect_ev(K_STEP, r0 + RD + 1 + RP * j);
    wait_until(r0 - 1);
    check("bounce_db_not_yet", {4'd0, btn_db}, 8'h00);
    wait_until(r0 + 1);
    check("hold_db", {4'd0, btn_db}, 8'h01);
    wait_until(r0 + 37);
    btn[0] = 1'b0;
    rel = int'(cyc);
    btn_dn(0, rel + DB + 2);
    wait_until(rel + 20);
    check("release_db", {4'd0, btn_db}, 8'h00);

    // Short press from IDLE: one step, released during DELAY.
    btn[0] = 1'b1;
    r0 = int'(cyc) + DB + 2;
    btn_up(0, r0);
    expect_ev(K_STEP, r0 + 1);
    wait_until(r0 + 2);
    btn[0] = 1'b0;
    rel = int'(cyc);
    btn_dn(0, rel + DB + 2);
    wait_until(rel + 20);

    // Three-cycle pulse on btn[2] is rejected.
    btn[2] = 1'b1; tick(3);
    btn[2] = 1'b0; tick(12);
    check("glitch_btn2_db", {4'd0, btn_db}, 8'h00);

    // btn[3:1] together: edges only, no step.
    btn[3:1] = 3'b111;
    t = int'(cyc);
    for (int b = 1; b < 4; b++) btn_up(b, t + DB + 2);
    wait_until(t + 10);
    check("btn_hi_db", {4'd0, btn_db}, 8'h0e);
    btn[3:1] = 3'b000;
    t = int'(cyc);
    for (int b = 1; b < 4; b++) btn_dn(b, t + DB + 2);
    wait_until(t + 10);
    check("btn_lo_db", {4'd0, btn_db}, 8'h00);

    // Direction switch latency and glitch immunity.
    sw[1] = 1'b1;
    t = int'(cyc);
    expect_ev(K_DIRUP, t + DB + 2);
    wait_until(t + DB + 1);
    check("dir_before", {7'd0, dir}, 8'd0);
    wait_until(t + DB + 2);
    check("dir_after", {7'd0, dir}, 8'd1);
    tick(4);
    sw[1] = 1'b0; tick(2);
    sw[1] = 1'b1; tick(12);
    check("dir_glitch", {7'd0, dir}, 8'd1);
    sw[0] = 1'b1;
    t = int'(cyc);
    expect_ev(K_SW0UP, t + DB + 2);
    wait_until(t + 10);
    check("sw_db_both", {6'd0, sw_db}, 8'd3);
    sw = 2'b00;
    t = int'(cyc);
    expect_ev(K_DIRDN, t + DB + 2);
    expect_ev(K_SW0DN, t + DB + 2);
    wait_until(t + 10);
    check("sw_db_off", {6'd0, sw_db}, 8'd0);

    // Reset while a step is high in REPEAT, button still held.
    btn[0] = 1'b1;
    r0 = int'(cyc) + DB + 2;
    btn_up(0, r0);
    expect_ev(K_STEP, r0 + 1);
    expect_ev(K_STEP, r0 + RD + 1);
    expect_ev(K_STEP, r0 + RD + 1 + RP);
    wait_until(r0 + RD + 1 + RP);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_btn_db", {4'd0, btn_db}, 8'd0);
    check("mid_rst_rise",   {4'd0, btn_rise}, 8'd0);
    check("mid_rst_fall",   {4'd0, btn_fall}, 8'd0);
    check("mid_rst_sw_db",  {6'd0, sw_db}, 8'd0);
    check("mid_rst_step",   {7'd0, step}, 8'd0);
    check("mid_rst_dir",    {7'd0, dir}, 8'd0);
    tick(3);
    #1 rst = 1'b0;
    t = int'(cyc);
    btn_up(0, t + DB + 2);
    expect_ev(K_STEP, t + 7);
    expect_ev(K_STEP, t + 17);
    expect_ev(K_STEP, t + 20);
    expect_ev(K_STEP, t + 23);
    wait_until(t + 5);
    check("post_rst_db_low", {4'd0, btn_db}, 8'd0);
    wait_until(t + 18);
    btn[0] = 1'b0;
    btn_dn(0, t + 24);
    wait_until(t + 40);
    check("final_db", {4'd0, btn_db}, 8'd0);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d pending events, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
